// File: rtl/alu_seq_if.sv
// Operand, ALU and result signals between the ALU sequencer and its producer/consumer.
interface alu_seq_if #(
  parameter int G_N_BIT = 7
);
  logic             i_in_valid;
  logic             o_in_ready;
  logic [G_N_BIT:0] i_in_data;
  logic             i_in_acc;
  logic             i_acc_clr;
  logic [G_N_BIT:0] o_s1;
  logic [G_N_BIT:0] o_s2;
  logic [G_N_BIT:0] i_res;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [G_N_BIT:0] o_out_data;
  logic [G_N_BIT:0] o_acc;

  modport slave (
    input  i_in_valid, i_in_data, i_in_acc, i_acc_clr, i_res, i_out_ready,
    output o_in_ready, o_s1, o_s2, o_out_valid, o_out_data, o_acc
  );

  modport master (
    output i_in_valid, i_in_data, i_in_acc, i_acc_clr, i_res, i_out_ready,
    input  o_in_ready, o_s1, o_s2, o_out_valid, o_out_data, o_acc
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequential front end for a combinational ALU: collects operands, holds them for
// G_LAT cycles, captures the result and keeps a chaining accumulator.
module alu_sequencer #(
  parameter int G_N_BIT = 7,
  parameter int G_LAT   = 1
) (
  input  logic      i_clk,
  input  logic      i_rst,
  alu_seq_if.slave  bus
);
  localparam int W = G_N_BIT + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT_B = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [3:0] LAT_M1 = 4'(G_LAT - 1);

  logic [1:0]   state;
  logic [3:0]   cnt;
  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] acc;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         in_ready;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = bus.i_in_valid & in_ready;
  assign out_fire = out_valid & bus.i_out_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      s1        <= '0;
      s2        <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_fire) begin
            if (bus.i_in_acc) begin
              s1       <= acc;
              s2       <= bus.i_in_data;
              cnt      <= LAT_M1;
              in_ready <= 1'b0;
              state    <= S_EXEC;
            end else begin
              s1    <= bus.i_in_data;
              state <= S_WAIT_B;
            end
          end
        end
        S_WAIT_B: begin
          if (in_fire) begin
            s2       <= bus.i_in_data;
            cnt      <= LAT_M1;
            in_ready <= 1'b0;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == 4'd0) begin
            out_data  <= bus.i_res;
            acc       <= bus.i_res;
            out_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          if (out_fire) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
      // Placed last so a clear beats a same-edge capture; s1 above still saw the old acc.
      if (bus.i_acc_clr) acc <= '0;
    end
  end

  assign bus.o_in_ready  = in_ready;
  assign bus.o_out_valid = out_valid;
  assign bus.o_out_data  = out_data;
  assign bus.o_s1        = s1;
  assign bus.o_s2        = s2;
  assign bus.o_acc       = acc;
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised self-checking bench for alu_sequencer with an adder as the ALU, run on
// two instances (G_LAT=1 and G_LAT=3) selected by sel.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       valid = 1'b0;
  logic       accm = 1'b0;
  logic       clr = 1'b0;
  logic       oready = 1'b0;
  logic [7:0] data = 8'h00;

  alu_seq_if #(.G_N_BIT(7)) b1();
  alu_seq_if #(.G_N_BIT(7)) b3();

  alu_sequencer #(.G_N_BIT(7), .G_LAT(1)) u1 (.i_clk(clk), .i_rst(rst), .bus(b1.slave));
  alu_sequencer #(.G_N_BIT(7), .G_LAT(3)) u3 (.i_clk(clk), .i_rst(rst), .bus(b3.slave));

  assign b1.i_in_valid  = valid & ~sel;
  assign b3.i_in_valid  = valid & sel;
  assign b1.i_out_ready = oready & ~sel;
  assign b3.i_out_ready = oready & sel;
  assign b1.i_in_data   = data;
  assign b3.i_in_data   = data;
  assign b1.i_in_acc    = accm;
  assign b3.i_in_acc    = accm;
  assign b1.i_acc_clr   = clr;
  assign b3.i_acc_clr   = clr;
  assign b1.i_res       = b1.o_s1 + b1.o_s2;
  assign b3.i_res       = b3.o_s1 + b3.o_s2;

  wire       in_ready  = sel ? b3.o_in_ready  : b1.o_in_ready;
  wire       out_valid = sel ? b3.o_out_valid : b1.o_out_valid;
  wire [7:0] out_data  = sel ? b3.o_out_data  : b1.o_out_data;
  wire [7:0] s1        = sel ? b3.o_s1        : b1.o_s1;
  wire [7:0] s2        = sel ? b3.o_s2        : b1.o_s2;
  wire [7:0] acc       = sel ? b3.o_acc       : b1.o_acc;

  int checks = 0;
  int failures = 0;
  logic [7:0] ref_acc [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic m, output bit ok);
    int n = 0;
    valid = 1'b1;
    data  = d;
    accm  = m;
    #1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    ok = in_ready;
    if (ok) tick();
    valid = 1'b0;
    accm  = 1'b0;
  endtask

  task automatic do_op(input bit m, input logic [7:0] a, input logic [7:0] b,
                       input bit ignored_acc, output bit ok, output int lat,
                       output logic [7:0] res);
    bit ok1 = 1'b1;
    bit ok2;
    if (!m) begin
      send(a, 1'b0, ok1);
      send(b, ignored_acc, ok2);
    end else begin
      send(b, 1'b1, ok2);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    ok  = ok1 && ok2 && out_valid;
    res = out_data;
  endtask

  task automatic take_output();
    oready = 1'b1;
    tick();
    oready = 1'b0;
  endtask

  function automatic int lat_of(input logic s);
    return s ? 3 : 1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ref_acc[0] = 8'h00;
    ref_acc[1] = 8'h00;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_hs sel=%0d got ready=%b valid=%b want 1 0", s, in_ready, out_valid);
      end
      checks++;
      if ({s1, s2, acc, out_data} !== 32'h0) begin
        failures++;
        $display("FAIL reset_data sel=%0d got %h %h %h %h want all 0", s, s1, s2, acc, out_data);
      end
    end
    sel = 1'b0;
    #1;
  endtask

  task automatic test_two_operand();
    bit ok;
    int lat;
    logic [7:0] res;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      do_op(1'b0, 8'h12, 8'h34, 1'b0, ok, lat, res);
      checks++;
      if (!ok || lat != lat_of(sel)) begin
        failures++;
        $display("FAIL two_op_latency sel=%0d got lat=%0d ok=%b want lat=%0d", s, lat, ok, lat_of(sel));
      end
      checks++;
      if (s1 !== 8'h12 || s2 !== 8'h34) begin
        failures++;
        $display("FAIL two_op_operands sel=%0d got %h %h want 12 34", s, s1, s2);
      end
      checks++;
      if (res !== 8'h46 || acc !== 8'h46) begin
        failures++;
        $display("FAIL two_op_result sel=%0d got res=%h acc=%h want 46", s, res, acc);
      end
      take_output();
      ref_acc[s] = 8'h46;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL two_op_release sel=%0d got ready=%b valid=%b want 1 0", s, in_ready, out_valid);
      end
    end
    sel = 1'b0;
    #1;
  endtask

  task automatic test_acc_chain();
    bit ok;
    int lat;
    logic [7:0] res;
    logic [7:0] vals [2];
    logic [7:0] want [2];
    vals[0] = 8'h10; vals[1] = 8'hC0;
    want[0] = 8'h56; want[1] = 8'h16;
    sel = 1'b0;
    #1;
    do_op(1'b0, 8'h12, 8'h34, 1'b0, ok, lat, res);
    take_output();
    ref_acc[0] = 8'h46;
    for (int i = 0; i < 2; i++) begin
      do_op(1'b1, 8'h00, vals[i], 1'b0, ok, lat, res);
      checks++;
      if (!ok || lat != 1 || res !== want[i] || acc !== want[i]) begin
        failures++;
        $display("FAIL acc_chain[%0d] got ok=%b lat=%0d res=%h acc=%h want lat=1 %h",
                 i, ok, lat, res, acc, want[i]);
      end
      checks++;
      if (s1 !== ref_acc[0]) begin
        failures++;
        $display("FAIL acc_chain_s1[%0d] got %h want %h", i, s1, ref_acc[0]);
      end
      ref_acc[0] = want[i];
      take_output();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [7:0] res;
    sel = 1'b0;
    #1;
    do_op(1'b0, 8'h20, 8'h22, 1'b0, ok, lat, res);
    valid = 1'b1;
    accm  = 1'b0;
    data  = 8'h77;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h42 || in_ready !== 1'b0 || s2 !== 8'h22) begin
        failures++;
        $display("FAIL backpressure_hold[%0d] got valid=%b data=%h ready=%b s2=%h want 1 42 0 22",
                 i, out_valid, out_data, in_ready, s2);
      end
    end
    take_output();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s1 !== 8'h20) begin
      failures++;
      $display("FAIL backpressure_release got ready=%b valid=%b s1=%h want 1 0 20", in_ready, out_valid, s1);
    end
    tick();
    valid = 1'b0;
    checks++;
    if (s1 !== 8'h77 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_next_beat got s1=%h ready=%b want 77 1", s1, in_ready);
    end
    send(8'h01, 1'b0, ok);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    checks++;
    if (out_data !== 8'h78 || lat != 1) begin
      failures++;
      $display("FAIL backpressure_result got %h lat=%0d want 78 lat=1", out_data, lat);
    end
    take_output();
    ref_acc[0] = 8'h78;
  endtask

  task automatic test_clear();
    bit ok;
    int lat;
    logic [7:0] res;
    sel = 1'b0;
    #1;
    send(8'h01, 1'b0, ok);
    send(8'h02, 1'b0, ok);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ref_acc[0] = 8'h00;
    ref_acc[1] = 8'h00;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h03 || acc !== 8'h00) begin
      failures++;
      $display("FAIL clear_on_capture got valid=%b data=%h acc=%h want 1 03 00", out_valid, out_data, acc);
    end
    take_output();
    do_op(1'b0, 8'h12, 8'h34, 1'b0, ok, lat, res);
    take_output();
    valid = 1'b1;
    accm  = 1'b1;
    data  = 8'h01;
    clr   = 1'b1;
    tick();
    valid = 1'b0;
    accm  = 1'b0;
    clr   = 1'b0;
    checks++;
    if (s1 !== 8'h46 || s2 !== 8'h01 || acc !== 8'h00) begin
      failures++;
      $display("FAIL clear_on_acc_beat got s1=%h s2=%h acc=%h want 46 01 00", s1, s2, acc);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    checks++;
    if (out_data !== 8'h47 || acc !== 8'h47 || lat != 1) begin
      failures++;
      $display("FAIL clear_acc_result got data=%h acc=%h lat=%0d want 47 47 1", out_data, acc, lat);
    end
    take_output();
    ref_acc[0] = 8'h47;
  endtask

  task automatic test_reset_midop();
    bit ok;
    int lat;
    logic [7:0] res;
    for (int phase = 0; phase < 2; phase++) begin
      sel = phase[0];
      #1;
      if (phase == 0) begin
        send(8'h55, 1'b0, ok);
      end else begin
        do_op(1'b0, 8'h55, 8'h66, 1'b0, ok, lat, res);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ref_acc[0] = 8'h00;
      ref_acc[1] = 8'h00;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || s1 !== 8'h00 || acc !== 8'h00 || out_data !== 8'h00) begin
        failures++;
        $display("FAIL reset_midop[%0d] got ready=%b valid=%b s1=%h acc=%h data=%h want 1 0 00 00 00",
                 phase, in_ready, out_valid, s1, acc, out_data);
      end
      do_op(1'b0, 8'h01, 8'h01, 1'b0, ok, lat, res);
      checks++;
      if (!ok || res !== 8'h02 || lat != lat_of(sel)) begin
        failures++;
        $display("FAIL reset_midop_next[%0d] got res=%h lat=%0d want 02 lat=%0d", phase, res, lat, lat_of(sel));
      end
      take_output();
      ref_acc[phase] = 8'h02;
    end
    sel = 1'b0;
    #1;
  endtask

  task automatic test_random();
    bit ok;
    bit m;
    int lat;
    int hold;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] exp;
    logic [7:0] exp_s1;
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      #1;
      if ($urandom_range(0, 7) == 0) begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ref_acc[0] = 8'h00;
        ref_acc[1] = 8'h00;
      end
      m = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      exp    = m ? 8'(ref_acc[sel] + b) : 8'(a + b);
      exp_s1 = m ? ref_acc[sel] : a;
      do_op(m, a, b, 1'($urandom_range(0, 1)), ok, lat, res);
      checks++;
      if (!ok || lat != lat_of(sel) || res !== exp || s1 !== exp_s1 || s2 !== b) begin
        failures++;
        $display("FAIL random[%0d] sel=%0d m=%b got ok=%b lat=%0d res=%h s1=%h s2=%h want lat=%0d %h %h %h",
                 i, sel, m, ok, lat, res, s1, s2, lat_of(sel), exp, exp_s1, b);
      end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp || acc !== exp) begin
        failures++;
        $display("FAIL random_hold[%0d] got valid=%b data=%h acc=%h want 1 %h", i, out_valid, out_data, acc, exp);
      end
      take_output();
      ref_acc[sel] = exp;
    end
    sel = 1'b0;
    #1;
  endtask

  initial begin
    test_reset();
    test_two_operand();
    test_acc_chain();
    test_backpressure();
    test_clear();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequential front end for the combinational `Alu` block. It accepts operand bytes over a valid/ready input stream and holds them stable on the ALU operand inputs. After a fixed settle time it captures the ALU result and returns it over a valid/ready output stream. It also keeps a result accumulator so chained operations need only one new operand each.

## Interface

- `G_N_BIT`, default 7: MSB index of data paths; data width W = `G_N_BIT`+1 (8 by default).
- `G_LAT`, default 1, range 1..15: number of cycles the ALU inputs are held before the result is sampled.
- `i_clk`, input, 1: clock; all state updates on the rising edge.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `i_in_valid`, input, 1: an input operand beat is offered.
- `o_in_ready`, output, 1: sequencer can take an operand beat.
- `i_in_data`, input, W: operand value.
- `i_in_acc`, input, 1: sampled on the first beat of an operation only; 1 selects accumulator mode.
- `i_acc_clr`, input, 1: clear accumulator to 0.
- `o_s1`, output, W: ALU operand 1.
- `o_s2`, output, W: ALU operand 2.
- `i_res`, input, W: ALU result.
- `o_out_valid`, output, 1: result held and offered.
- `i_out_ready`, input, 1: consumer accepts the result.
- `o_out_data`, output, W: captured result.
- `o_acc`, output, W: current accumulator value.

## Operation

- A beat transfers on a rising edge where `i_in_valid` and `o_in_ready` are both 1. The same rule applies to the output with `o_out_valid` and `i_out_ready`.
- FSM states: IDLE, WAIT_B, EXEC, RESP. `o_in_ready` is 1 only in IDLE and WAIT_B.
- IDLE: on a transfer:
  - If `i_in_acc`=0: register `i_in_data` into s1, go to WAIT_B.
  - If `i_in_acc`=1: s1 <= acc, s2 <= `i_in_data`, load the latency counter with `G_LAT`-1, go to EXEC.
- WAIT_B: on a transfer, s2 <= `i_in_data`, load the counter with `G_LAT`-1, go to EXEC. `i_in_acc` is ignored in this state.
- EXEC: `o_s1`/`o_s2` stay constant.
  - When the counter is 0: capture `i_res` into `o_out_data` and into acc, then go to RESP.
  - Otherwise decrement the counter.
- RESP: `o_out_valid`=1 and `o_out_data` is stable. On an output transfer, go to IDLE.
- `o_s1`/`o_s2` keep their registered values in every state. They change only on an operand transfer.
- Arithmetic: the sequencer never modifies data. Results are truncated or extended by the ALU only. acc is W bits.
- `i_acc_clr`:
  - Sets acc to 0 on the next edge in any state.
  - If it coincides with the EXEC capture edge, the clear wins: acc=0, `o_out_data` still gets `i_res`.
  - If it coincides with an accumulator-mode first beat, s1 takes the old acc value (the pre-edge value).
- Reset:
  - Values: state IDLE, s1=s2=0, acc=0, `o_out_data`=0, counter=0, `o_out_valid`=0, `o_in_ready`=1.
  - Reset mid-operation abandons any partial operand pair or pending result with no output transfer. Reset has priority over all other inputs.
- Unused combinations: `i_in_valid` while `o_in_ready`=0 is not consumed. The producer must hold the beat.

## Timing

- `o_in_ready`, `o_out_valid`, `o_out_data`, `o_s1`, `o_s2` and `o_acc` are register-driven. There is no combinational path from any input to any output.
- Two-operand op:
  - Beat A accepted at edge t0, beat B at edge t1 ≥ t0+1.
  - EXEC occupies edges t1+1 .. t1+`G_LAT`. The capture happens on edge t1+`G_LAT`.
  - `o_out_valid` rises after edge t1+`G_LAT`.
- Accumulator op: beat accepted at t0, `o_out_valid` after edge t0+`G_LAT`.
- Output handshake:
  - Output accepted at edge tr → `o_in_ready`=1 after tr.
  - Next operand earliest at tr+1; no overlap between operations.
- Peak throughput with `G_LAT`=1 and ready always asserted:
  - Two-operand mode: one result per 4 cycles.
  - Accumulator mode: one result per 3 cycles.
- Backpressure: `o_out_valid` and `o_out_data` are held indefinitely while `i_out_ready`=0.

## Test plan

The bench ALU model is a W-bit adder: `i_res` = (`o_s1`+`o_s2`) mod 2^W.

- Reset then idle: assert `i_rst` 2 cycles → `o_in_ready`=1, `o_out_valid`=0, `o_s1`=`o_s2`=`o_acc`=`o_out_data`=0.
- Two-operand op: beats 0x12, 0x34 with `G_LAT`=1 → `o_s1`=0x12, `o_s2`=0x34, `o_out_data`=0x46 exactly 1 edge after beat B. Repeat with `G_LAT`=3: 3 edges after beat B.
- Accumulator chain: 0x12, 0x34 (acc=0x46), then acc beats 0x10 and 0xC0 → results 0x56 then 0x16 (wrap).
- Backpressure: hold `i_out_ready`=0 for 10 cycles with `i_in_valid`=1 → `o_out_data` stable, `o_in_ready`=0, no beat consumed; release → next beat accepted one edge after the output transfer.
- Simultaneous clear: `i_acc_clr` on the EXEC capture edge of 0x01+0x02 → `o_out_data`=0x03, `o_acc`=0. Clear on an acc-mode first beat with acc=0x46 and data 0x01 → result 0x47, acc=0x47.
- Reset mid-op: `i_rst` in WAIT_B after beat 0x55, and separately in RESP → IDLE, `o_out_valid`=0 with no output transfer; following pair 0x01, 0x01 → result 0x02.
